// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: FSM state encoding, line-filter length, timing defaults.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ps2_pkg;

  // Consecutive stable samples required before a line level is accepted
  localparam int PS2_FILT_LEN   = 8;
  // Host clock-inhibit time before a request-to-send
  localparam int PS2_INHIBIT_US = 120;
  // Per-transaction watchdog once the device owns the clock
  localparam int PS2_TIMEOUT_MS = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_RELEASE,
    ST_FINISH
  } ps2_state_t;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-flop synchronizer, stable-level filter, falling-edge flag.
// Latency: 2 sync cycles + PS2_FILT_LEN stable cycles from pin change to o_level.
// Backpressure: none; free-running, o_fall is a single-cycle strobe.
module ps2_line_filter
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_line,
  output logic o_level,
  output logic o_fall
);

  localparam int CW = $clog2(PS2_FILT_LEN);

  logic          r_meta;
  logic          r_sync;
  logic          r_level;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // Synchronize, then accept a new level only after it has held for PS2_FILT_LEN cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta  <= 1'b1;
      r_sync  <= 1'b1;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_fall <= 1'b0;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(PS2_FILT_LEN - 1)) begin
        r_level <= r_sync;
        r_cnt   <= '0;
        // Old level was 1 and is now being replaced by 0: that is a falling edge
        r_fall  <= r_level;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command sender: inhibit, request-to-send, 10-bit shift, ACK check.
// Latency: INH_CYC cycles of inhibit, then paced by the device clock; done/error 1 cycle after close.
// Backpressure: start is accepted only in IDLE with busy=0; requests while busy are dropped.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLKFREQ    = 25000000,
  parameter int INHIBIT_US = PS2_INHIBIT_US,
  parameter int TIMEOUT_MS = PS2_TIMEOUT_MS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       clkps2_in,
  input  logic       dataps2_in,
  output logic       clkps2_oe,
  output logic       dataps2_oe
);

  localparam int INH_CYC = CLKFREQ / 1000000 * INHIBIT_US;
  localparam int TO_CYC  = CLKFREQ / 1000 * TIMEOUT_MS;
  localparam int INH_W   = $clog2(INH_CYC + 1);
  localparam int TO_W    = $clog2(TO_CYC + 1);

  ps2_state_t       r_state;
  ps2_state_t       w_nxt;
  logic [9:0]       r_frame;
  logic [3:0]       r_idx;
  logic [INH_W-1:0] r_cnt;
  logic [TO_W-1:0]  r_wd;
  logic             r_data_oe;
  logic             r_ok;

  logic w_clk_lvl;
  logic w_clk_fall;
  logic w_dat_lvl;
  logic w_dat_fall;
  logic w_to;
  logic w_inh_last;
  logic w_rel_ok;

  ps2_line_filter u_clk_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_line  (clkps2_in),
    .o_level (w_clk_lvl),
    .o_fall  (w_clk_fall)
  );

  ps2_line_filter u_dat_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_line  (dataps2_in),
    .o_level (w_dat_lvl),
    .o_fall  (w_dat_fall)
  );

  assign w_inh_last = (r_cnt == INH_W'(INH_CYC - 1));
  assign w_to       = (r_wd == TO_W'(TO_CYC - 1));
  // Bus is idle once both lines read high and data is not mid-transition
  assign w_rel_ok   = w_clk_lvl && w_dat_lvl && !w_dat_fall;

  // State register; reset drops to IDLE so both lines are released asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  // Next-state: watchdog expiry overrides everything once the device owns the clock
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_nxt = ST_INHIBIT;
      ST_INHIBIT: if (w_inh_last) w_nxt = ST_REQ;
      ST_REQ:     w_nxt = w_to ? ST_FINISH : ST_SHIFT;
      ST_SHIFT: begin
        if (w_to)                             w_nxt = ST_FINISH;
        else if (w_clk_fall && r_idx == 4'd9) w_nxt = ST_ACK;
      end
      ST_ACK: begin
        if (w_to)            w_nxt = ST_FINISH;
        else if (w_clk_fall) w_nxt = w_dat_lvl ? ST_FINISH : ST_RELEASE;
      end
      ST_RELEASE: if (w_to || w_rel_ok) w_nxt = ST_FINISH;
      ST_FINISH:  w_nxt = ST_IDLE;
      default:    w_nxt = ST_IDLE;
    endcase
  end

  // Datapath: frame latch, inhibit counter, bit index, watchdog, shifted data drive, outcome
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame   <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_wd      <= '0;
      r_data_oe <= 1'b0;
      r_ok      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          r_ok  <= 1'b0;
          if (start) r_frame <= {1'b1, odd_parity(data), data};
        end
        ST_INHIBIT: begin
          r_cnt <= r_cnt + INH_W'(1);
          r_wd  <= '0;
        end
        ST_REQ: begin
          r_idx     <= '0;
          r_data_oe <= 1'b1;
          r_wd      <= r_wd + TO_W'(1);
        end
        ST_SHIFT: begin
          r_wd <= r_wd + TO_W'(1);
          // Host drives the next bit while the device holds the clock low
          if (w_clk_fall) begin
            r_data_oe <= ~r_frame[r_idx];
            r_idx     <= r_idx + 4'd1;
          end
        end
        ST_ACK: r_wd <= r_wd + TO_W'(1);
        ST_RELEASE: begin
          r_wd <= r_wd + TO_W'(1);
          r_ok <= !w_to && w_rel_ok;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; FINISH is the only state with a pulse and busy low
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    clkps2_oe  = 1'b0;
    dataps2_oe = 1'b0;
    case (r_state)
      ST_INHIBIT: begin
        busy       = 1'b1;
        clkps2_oe  = 1'b1;
        dataps2_oe = w_inh_last;
      end
      ST_REQ: begin
        busy       = 1'b1;
        dataps2_oe = 1'b1;
      end
      ST_SHIFT: begin
        busy       = 1'b1;
        dataps2_oe = r_data_oe;
      end
      ST_ACK, ST_RELEASE: busy = 1'b1;
      ST_FINISH: begin
        done  = r_ok;
        error = ~r_ok;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
// Runs at a 1 MHz nominal clock so inhibit is 3000 cycles and the watchdog 2000 cycles.
// Device clock is 12.5 kHz (40 cycles low, 40 high).
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int EXP_INH = 3000;
  localparam int EXP_TO  = 2000;
  localparam int HALF    = 40;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       start   = 1'b0;
  logic [7:0] data    = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       busy, done, error, clkps2_oe, dataps2_oe;

  wire clkps2_in  = dev_clk & ~clkps2_oe;
  wire dataps2_in = dev_dat & ~dataps2_oe;

  int n_checks  = 0;
  int n_fail    = 0;
  int done_cnt  = 0;
  int err_cnt   = 0;
  int both_cnt  = 0;
  int pbase     = 0;
  bit busy_ok   = 1'b1;

  ps2_host_tx #(
    .CLKFREQ    (1000000),
    .INHIBIT_US (3000),
    .TIMEOUT_MS (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .clkps2_in  (clkps2_in),
    .dataps2_in (dataps2_in),
    .clkps2_oe  (clkps2_oe),
    .dataps2_oe (dataps2_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done)          done_cnt = done_cnt + 1;
    if (error)         err_cnt  = err_cnt + 1;
    if (done && error) both_cnt = both_cnt + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "time limit");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n cycles; note any cycle where busy is low before the outcome pulse
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (!busy && !done && !error && (done_cnt + err_cnt) == pbase) busy_ok = 1'b0;
    end
  endtask

  // Issue start and measure the inhibit window up to the REQ cycle
  task automatic xfer_start(input logic [7:0] d, input bit poke,
                            output int inh, output int dpos, output logic soe);
    int guard;
    @(negedge clk);
    data    = d;
    start   = 1'b1;
    pbase   = done_cnt + err_cnt;
    busy_ok = 1'b1;
    @(negedge clk);
    start = 1'b0;
    inh   = 0;
    dpos  = -1;
    guard = 0;
    while (clkps2_oe && guard < 10000) begin
      if (dataps2_oe && dpos < 0) dpos = inh;
      if (poke && inh == 100) begin
        data  = 8'h00;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      inh++;
      guard++;
      cyc(1);
    end
    start = 1'b0;
    soe   = dataps2_oe;
  endtask

  // Device generates nedges clock pulses, samples the line before each rising edge
  task automatic dev_clock(input int nedges, input bit ack, output logic [9:0] bits);
    bits = '0;
    for (int k = 0; k < nedges; k++) begin
      if (k == 10) dev_dat = ack ? 1'b0 : 1'b1;
      cyc(HALF);
      dev_clk = 1'b0;
      cyc(HALF);
      if (k < 10) bits[k] = dataps2_in;
      dev_clk = 1'b1;
    end
    cyc(HALF);
    dev_dat = 1'b1;
  endtask

  task automatic wait_pulse();
    int guard = 0;
    while ((done_cnt + err_cnt) == pbase && guard < 500) begin
      cyc(1);
      guard++;
    end
    cyc(5);
  endtask

  task automatic full_xfer(input string tag, input logic [7:0] d, input bit ack,
                           input bit poke, input logic [9:0] exp_bits);
    int inh, dpos, d0, e0;
    logic soe;
    logic [9:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    xfer_start(d, poke, inh, dpos, soe);
    check_eq({tag, "_inh_len"}, inh, EXP_INH);
    check_eq({tag, "_doe_pos"}, dpos, EXP_INH - 1);
    check_eq({tag, "_start_bit"}, {31'd0, soe}, 32'd1);
    dev_clock(11, ack, bits);
    check_eq({tag, "_line_bits"}, {22'd0, bits}, {22'd0, exp_bits});
    wait_pulse();
    check_eq({tag, "_done_cnt"}, done_cnt - d0, ack ? 1 : 0);
    check_eq({tag, "_err_cnt"}, err_cnt - e0, ack ? 0 : 1);
    if (ack) check_eq({tag, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
    check_eq({tag, "_oe_after"}, {30'd0, clkps2_oe, dataps2_oe}, 32'd0);
  endtask

  initial begin
    int inh, dpos, n, d0, e0;
    logic soe;
    logic [9:0] bits;
    bit idle_bad;

    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_error", {31'd0, error}, 32'd0);
    check_eq("rst_clk_oe", {31'd0, clkps2_oe}, 32'd0);
    check_eq("rst_dat_oe", {31'd0, dataps2_oe}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Device clock edges while idle must not wake the host
    idle_bad = 1'b0;
    for (int i = 0; i < 120; i++) begin
      dev_clk = ((i / 20) % 2) != 0;
      @(negedge clk);
      if (clkps2_oe || dataps2_oe || busy) idle_bad = 1'b1;
    end
    dev_clk = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("idle_ignore", {31'd0, idle_bad}, 32'd0);
    check_eq("idle_no_pulse", done_cnt + err_cnt, 32'd0);

    full_xfer("xed", 8'hED, 1'b1, 1'b0, 10'h3ED);

    // Extra start during inhibit must be neither taken nor queued
    full_xfer("x01", 8'h01, 1'b1, 1'b1, 10'h201);
    cyc(50);
    check_eq("no_queue", {30'd0, clkps2_oe, busy}, 32'd0);

    full_xfer("xff", 8'hFF, 1'b1, 1'b0, 10'h3FF);
    full_xfer("nak", 8'hAA, 1'b0, 1'b0, 10'h3AA);

    // Device never clocks: watchdog from the REQ cycle
    d0 = done_cnt;
    e0 = err_cnt;
    xfer_start(8'h55, 1'b0, inh, dpos, soe);
    n = 0;
    while (!error && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq("to_cycles", n, EXP_TO);
    @(negedge clk);
    check_eq("to_oe_after", {30'd0, clkps2_oe, dataps2_oe}, 32'd0);
    cyc(5);
    check_eq("to_err_cnt", err_cnt - e0, 32'd1);
    check_eq("to_done_cnt", done_cnt - d0, 32'd0);

    // Reset in the middle of the shift, after bit 4 (a 0) is on the line
    d0 = done_cnt;
    e0 = err_cnt;
    xfer_start(8'h0F, 1'b0, inh, dpos, soe);
    dev_clock(5, 1'b0, bits);
    cyc(10);
    check_eq("rst_mid_busy_pre", {31'd0, busy}, 32'd1);
    check_eq("rst_mid_doe_pre", {31'd0, dataps2_oe}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_oe", {30'd0, clkps2_oe, dataps2_oe}, 32'd0);
    check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("rst_mid_no_pulse", (done_cnt - d0) + (err_cnt - e0), 32'd0);

    full_xfer("xf4", 8'hF4, 1'b1, 1'b0, 10'h2F4);

    check_eq("never_both", both_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The module SHALL have parameter CLKFREQ, default 25000000, giving the system clock frequency in Hz.
REQ-002 The module SHALL have parameter INHIBIT_US, default 120, giving the host clock-inhibit time in microseconds.
REQ-003 The module SHALL have parameter TIMEOUT_MS, default 15, giving the per-transaction watchdog time in milliseconds.
REQ-004 The module SHALL have port clk, input, 1 bit: the only clock; all logic is rising-edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The module SHALL have port data, input, 8 bits: the command byte, sampled when start is accepted.
REQ-007 The module SHALL have port start, input, 1 bit: a one-cycle request, accepted only when busy=0.
REQ-008 The module SHALL have port busy, output, 1 bit: high from the cycle after acceptance until done/error.
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle pulse when the device acknowledged.
REQ-010 The module SHALL have port error, output, 1 bit: one-cycle pulse on a missing ACK or a timeout.
REQ-011 The module SHALL have port clkps2_in, input, 1 bit: the PS/2 clock line, asynchronous.
REQ-012 The module SHALL have port dataps2_in, input, 1 bit: the PS/2 data line, asynchronous.
REQ-013 The module SHALL have port clkps2_oe, output, 1 bit: 1 pulls the PS/2 clock low (open drain); 0 releases it.
REQ-014 The module SHALL have port dataps2_oe, output, 1 bit: 1 pulls the PS/2 data low (open drain); 0 releases it.

Function
REQ-015 Each PS/2 input SHALL pass a 2-flop synchronizer and an 8-cycle stable-level filter; a falling edge SHALL be flagged for one cycle when the filtered level goes 1->0.
REQ-016 Derived constants SHALL be: INH_CYC = CLKFREQ/1000000*INHIBIT_US, which is 3000 at default; TO_CYC = CLKFREQ/1000*TIMEOUT_MS, which is 375000 at default.
REQ-017 FSM states SHALL be IDLE, INHIBIT, REQ, SHIFT, ACK, RELEASE, FINISH.
REQ-018 IDLE: when start=1, the FSM SHALL latch data, compute odd parity p = ~^data, form the 10-bit frame {1(stop), p, data}, go to INHIBIT, and assert busy the next cycle.
REQ-019 INHIBIT: clkps2_oe SHALL be 1 for INH_CYC cycles; dataps2_oe SHALL be set to 1 in the last cycle of INHIBIT.
REQ-020 REQ: clkps2_oe SHALL be 0 and dataps2_oe SHALL be 1 (start bit); bit index SHALL be 0; the FSM SHALL go to SHIFT.
REQ-021 SHIFT: on each filtered clock falling edge, dataps2_oe SHALL be ~frame[index] and index SHALL increment. After the edge presenting index 9 (stop, data released), the FSM SHALL go to ACK.
REQ-022 ACK: on the next falling edge, if filtered data=0 the FSM SHALL go to RELEASE; otherwise it SHALL go to FINISH with error.
REQ-023 RELEASE: the FSM SHALL wait until both filtered lines are 1, then go to FINISH with done.
REQ-024 FINISH: the FSM SHALL pulse done or error for exactly one cycle, deassert busy in the same cycle, and return to IDLE.
REQ-025 The watchdog SHALL count from entry to REQ; reaching TO_CYC in REQ, SHIFT, ACK, or RELEASE SHALL force both oe outputs to 0 and go to FINISH with error.
REQ-026 A start asserted while busy=1 SHALL be ignored with no queueing.
REQ-027 done and error SHALL never be asserted in the same cycle.
REQ-028 Falling edges on clkps2 while in IDLE SHALL be ignored, and the oe outputs SHALL stay 0.

Reset
REQ-029 While rst_n=0, the FSM SHALL be in IDLE and busy, done, error, clkps2_oe, dataps2_oe SHALL all be 0; the filters SHALL preset to 1 and the counters to 0.
REQ-030 Reset asserted mid-transaction SHALL release both lines immediately (asynchronously) and SHALL produce no done or error pulse.

Structure
REQ-031 Shared package ps2_pkg SHALL hold the FSM state encoding, the filter length (8), and the PS/2 timing defaults (INHIBIT_US, TIMEOUT_MS) for reuse by the existing PS/2 receiver.
REQ-032 One sub-module, ps2_line_filter (synchronizer, stable filter, falling-edge flag), SHALL be instantiated twice.

Verification
REQ-033 Scenario: data=0xED, device model clocks at 12.5 kHz and ACKs -> line bits LSB first 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; busy high throughout.
REQ-034 Scenario: data=0x01 -> parity bit 0; data=0xFF -> parity bit 1; both complete with done.
REQ-035 Scenario: after start -> clkps2_oe high for exactly 3000 cycles; dataps2_oe rises in the last of those cycles.
REQ-036 Scenario: device never clocks -> error pulses at 375000 cycles after REQ; both oe outputs are 0 afterwards.
REQ-037 Scenario: device leaves data high on the 11th clock -> error pulses, no done.
REQ-038 Scenario: rst_n=0 in SHIFT after bit 4 -> oe outputs are 0 immediately; no pulse; a subsequent 0xF4 transfer completes normally.
